// File: rtl/hazard_pkg.sv
// Shared widths and latencies for the pipeline hazard scoreboard.
// The optional MDU tracking is enabled with the HAZARD_MDU_EN macro.
package hazard_pkg;
  localparam int T_W       = 2;
  localparam int NREG      = 32;
  localparam int REG_W     = $clog2(NREG);
  localparam int MUL_LAT   = 5;
  localparam int DIV_LAT   = 10;
  localparam int MDU_CNT_W = 4;
endpackage

// File: rtl/mdu_busy_tracker.sv
// HI/LO busy countdown; only instantiated when HAZARD_MDU_EN is defined.
module mdu_busy_tracker
  import hazard_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic div,
  output logic busy
);
  logic [MDU_CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset)             cnt <= '0;
    else if (start)        cnt <= div ? MDU_CNT_W'(DIV_LAT) : MDU_CNT_W'(MUL_LAT);
    else if (cnt != '0)    cnt <= cnt - 1'b1;
  end

  assign busy = (cnt != '0);
endmodule

// File: rtl/hazard_scoreboard.sv
// Tnew/Tuse hazard scoreboard: per-register countdown to forwardability, D-stage stall.
// Define HAZARD_MDU_EN to add HI/LO busy tracking for mult/div.
module hazard_scoreboard
  import hazard_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             D_valid,
  input  logic [REG_W-1:0] D_rs,
  input  logic [REG_W-1:0] D_rt,
  input  logic             D_use_rs,
  input  logic             D_use_rt,
  input  logic [T_W-1:0]   D_Tuse_rs,
  input  logic [T_W-1:0]   D_Tuse_rt,
  input  logic             D_we,
  input  logic [REG_W-1:0] D_wa,
  input  logic [T_W-1:0]   D_Tnew,
`ifdef HAZARD_MDU_EN
  input  logic             D_is_md,
  input  logic             D_md_start,
  input  logic             D_md_div,
  output logic             md_busy,
`endif
  output logic             stall,
  output logic [15:0]      stall_cycles
);
  logic [NREG-1:0][T_W-1:0] pend;
  logic issue, load, haz_rs, haz_rt, haz_md;

  assign haz_rs = D_use_rs & (D_rs != '0) & (pend[D_rs] > D_Tuse_rs);
  assign haz_rt = D_use_rt & (D_rt != '0) & (pend[D_rt] > D_Tuse_rt);

`ifdef HAZARD_MDU_EN
  mdu_busy_tracker u_mdu (
    .clk   (clk),
    .reset (reset),
    .start (issue & D_md_start),
    .div   (D_md_div),
    .busy  (md_busy)
  );
  assign haz_md = D_is_md & md_busy;
`else
  assign haz_md = 1'b0;
`endif

  assign stall = D_valid & (haz_rs | haz_rt | haz_md);
  assign issue = D_valid & ~stall;
  assign load  = issue & D_we & (D_wa != '0);

  // A fresh load overrides the decrement of the same entry; $0 never pends.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend         <= '0;
      stall_cycles <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (r == 0)                           pend[r] <= '0;
        else if (load && D_wa == REG_W'(r))   pend[r] <= D_Tnew;
        else if (pend[r] != '0)               pend[r] <= pend[r] - 1'b1;
      end
      if (stall && stall_cycles != 16'hFFFF)  stall_cycles <= stall_cycles + 1'b1;
    end
  end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard with a ready-time model and per-cycle compare.
// Build with HAZARD_MDU_EN defined to exercise the MDU ports.
module tb_hazard_scoreboard;
  logic clk = 0, reset = 1;
  logic D_valid = 0, D_use_rs = 0, D_use_rt = 0, D_we = 0;
  logic [4:0] D_rs = 0, D_rt = 0, D_wa = 0;
  logic [1:0] D_Tuse_rs = 0, D_Tuse_rt = 0, D_Tnew = 0;
  logic stall;
  logic [15:0] stall_cycles;
`ifdef HAZARD_MDU_EN
  logic D_is_md = 0, D_md_start = 0, D_md_div = 0, md_busy;
`endif

  hazard_scoreboard dut (
    .clk(clk), .reset(reset), .D_valid(D_valid),
    .D_rs(D_rs), .D_rt(D_rt), .D_use_rs(D_use_rs), .D_use_rt(D_use_rt),
    .D_Tuse_rs(D_Tuse_rs), .D_Tuse_rt(D_Tuse_rt),
    .D_we(D_we), .D_wa(D_wa), .D_Tnew(D_Tnew),
`ifdef HAZARD_MDU_EN
    .D_is_md(D_is_md), .D_md_start(D_md_start), .D_md_div(D_md_div), .md_busy(md_busy),
`endif
    .stall(stall), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: absolute cycle at which each register (and HI/LO) becomes ready.
  int unsigned cyc = 0, m_cnt = 0, md_ready = 0;
  int unsigned ready [32];
  bit chk_en = 0;

  function automatic int unsigned rem(input logic [4:0] r);
    return (ready[r] > cyc) ? ready[r] - cyc : 0;
  endfunction

  function automatic bit m_stall();
    bit s;
    s = (D_use_rs && D_rs != 0 && rem(D_rs) > D_Tuse_rs) ||
        (D_use_rt && D_rt != 0 && rem(D_rt) > D_Tuse_rt);
`ifdef HAZARD_MDU_EN
    s = s || (D_is_md && md_ready > cyc);
`endif
    return D_valid && s;
  endfunction

  always @(posedge clk) begin
    bit s;
    s = m_stall();
    if (reset) begin
      foreach (ready[i]) ready[i] = 0;
      m_cnt = 0; md_ready = 0; chk_en = 1;
    end else begin
      if (s && m_cnt < 65535) m_cnt++;
      if (D_valid && !s) begin
        if (D_we && D_wa != 0) ready[D_wa] = cyc + 1 + D_Tnew;
`ifdef HAZARD_MDU_EN
        if (D_md_start) md_ready = cyc + 1 + (D_md_div ? 10 : 5);
`endif
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_stall", {31'b0, stall}, {31'b0, m_stall()});
      chk("model_stall_cycles", {16'b0, stall_cycles}, m_cnt);
`ifdef HAZARD_MDU_EN
      chk("model_md_busy", {31'b0, md_busy}, {31'b0, md_ready > cyc});
`endif
    end
  end

  task automatic tick(); @(posedge clk); #1; endtask

  task automatic clr();
    D_valid = 0; D_use_rs = 0; D_use_rt = 0; D_we = 0;
    D_rs = 0; D_rt = 0; D_wa = 0; D_Tuse_rs = 0; D_Tuse_rt = 0; D_Tnew = 0;
`ifdef HAZARD_MDU_EN
    D_is_md = 0; D_md_start = 0; D_md_div = 0;
`endif
  endtask

  task automatic producer(input logic [4:0] wa, input logic [1:0] tnew);
    clr(); D_valid = 1; D_we = 1; D_wa = wa; D_Tnew = tnew;
  endtask

  task automatic consumer(input logic [4:0] rs, input logic [1:0] tuse);
    clr(); D_valid = 1; D_use_rs = 1; D_rs = rs; D_Tuse_rs = tuse;
  endtask

  task automatic lit(input string name, input logic [31:0] exp_stall);
    @(negedge clk); chk(name, {31'b0, stall}, exp_stall);
  endtask

  initial begin
    clr();
    repeat (2) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("reset_stall", {31'b0, stall}, 0);
    chk("reset_stall_cycles", {16'b0, stall_cycles}, 0);
    tick();

    // lw $1 then dependent add with Tuse=1: one bubble
    producer(5'd1, 2'd2); lit("lw_issue", 0); tick();
    consumer(5'd1, 2'd1); D_we = 1; D_wa = 5'd4; D_Tnew = 2'd1;
    lit("lw_use_stall", 1); tick();
    lit("lw_use_release", 0);
    chk("lw_use_count", {16'b0, stall_cycles}, 1); tick();
    clr(); repeat (4) tick();

    // add $2 then beq: Tuse=0 stalls once, Tuse=1 does not
    producer(5'd2, 2'd1); tick();
    consumer(5'd2, 2'd0); lit("beq_tuse0_stall", 1); tick();
    lit("beq_tuse0_release", 0);
    chk("beq_count", {16'b0, stall_cycles}, 2); tick();
    producer(5'd2, 2'd1); tick();
    consumer(5'd2, 2'd1); lit("beq_tuse1_nostall", 0); tick();
    // same hazard seen on rt
    producer(5'd7, 2'd2); tick();
    clr(); D_valid = 1; D_use_rt = 1; D_rt = 5'd7; D_Tuse_rt = 2'd1;
    lit("rt_stall", 1); tick();
    lit("rt_release", 0); tick();
    clr(); repeat (4) tick();

    // writes to $0 never create a hazard
    producer(5'd0, 2'd2); tick();
    consumer(5'd0, 2'd0); D_use_rt = 1; lit("r0_nostall", 0); tick();
    // D_valid=0 masks a real hazard
    producer(5'd6, 2'd3); tick();
    consumer(5'd6, 2'd0); D_valid = 0; lit("invalid_nostall", 0); tick();
    D_valid = 1; lit("valid_stall", 1); tick();
    clr(); repeat (4) tick();

    // reset while a dependent instruction waits
    producer(5'd3, 2'd2); tick();
    consumer(5'd3, 2'd0); reset = 1; lit("pre_reset_stall", 1); tick();
    reset = 0; lit("post_reset_stall", 0);
    chk("post_reset_count", {16'b0, stall_cycles}, 0); tick();
    clr(); repeat (2) tick();

`ifdef HAZARD_MDU_EN
    begin
      int n;
      clr(); D_valid = 1; D_is_md = 1; D_md_start = 1; D_md_div = 1;
      @(negedge clk); chk("div_issue_busy", {31'b0, md_busy}, 0); tick();
      clr(); D_valid = 1; D_is_md = 1;
      n = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk); if (!stall) break; n++; tick();
      end
      chk("div_stall_len", n, 10);
      chk("div_busy_fall", {31'b0, md_busy}, 0); tick();
      clr(); D_valid = 1; D_is_md = 1; D_md_start = 1; tick();
      clr(); D_valid = 1; D_is_md = 1;
      n = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk); if (!stall) break; n++; tick();
      end
      chk("mult_stall_len", n, 5); tick();
      clr(); repeat (2) tick();
    end
`endif

    // self-dependent producer: stalls 3 of every 4 cycles until the counter saturates
    consumer(5'd5, 2'd0); D_we = 1; D_wa = 5'd5; D_Tnew = 2'd3;
    repeat (88000) tick();
    @(negedge clk);
    chk("sat_count", {16'b0, stall_cycles}, 32'h0000FFFF);
    clr(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have the following ports, clock and reset first:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- D_valid  in  1  D stage holds a real instruction
- D_rs, D_rt  in  5 each  D-stage source register numbers
- D_use_rs, D_use_rt  in  1 each  source is actually read
- D_Tuse_rs, D_Tuse_rt  in  2 each  cycles until the source value is needed
- D_we  in  1  instruction writes the GRF
- D_wa  in  5  destination register
- D_Tnew  in  2  cycles after E entry until the result is forwardable
- stall  out  1  drives the E-register bubble (blockSign) and the F/D hold
- stall_cycles  out  16  saturating count of stalled cycles
REQ-002 SHALL provide these ports only when HAZARD_MDU_EN is defined:
- D_is_md  in  1  D instruction reads or writes HI/LO
- D_md_start  in  1  D instruction is mult/multu/div/divu
- D_md_div  in  1  started op is a divide
- md_busy  out  1  MDU countdown nonzero

Function
REQ-003 SHALL hold a 32-entry array pend[r], each entry 2 bits, giving the remaining cycles until r is forwardable.
REQ-004 SHALL define issue as D_valid & ~stall, evaluated at the same posedge.
REQ-005 On issue with D_we=1 and D_wa≠0, SHALL load pend[D_wa] <= D_Tnew.
REQ-006 SHALL decrement every other nonzero pend entry by 1 at each posedge; entries SHALL saturate at 0.
REQ-007 When an issue and a decrement hit the same entry, the load SHALL win.
REQ-008 pend[0] SHALL read as 0 at all times.
REQ-009 stall SHALL be combinational from registered state and current inputs.
REQ-010 stall SHALL be 1 when D_valid and either:
- D_use_rs & D_rs≠0 & pend[D_rs] > D_Tuse_rs, or
- the same condition for rt.
REQ-011 During a stall, no pend entry SHALL be loaded; decrements SHALL continue.
REQ-012 stall_cycles SHALL increment on each posedge with stall=1 and SHALL saturate at 16'hFFFF.
REQ-013 With D_valid=0, stall SHALL be 0.

Reset
REQ-014 reset SHALL clear all pend entries, stall_cycles and (if built) the MDU countdown to 0; stall SHALL read 0 in the following cycle.
REQ-015 A reset asserted while entries are mid-countdown SHALL discard them; no stall SHALL persist after reset.

Configuration
REQ-016 Macro HAZARD_MDU_EN: when defined, SHALL include a 4-bit MDU countdown with the following behaviour:
- on issue with D_md_start, load MUL_LAT=5 or DIV_LAT=10 per D_md_div
- otherwise decrement to 0
- md_busy = (count≠0)
- stall additionally asserted when D_valid & D_is_md & md_busy
REQ-017 Without HAZARD_MDU_EN, the MDU ports, countdown and MDU stall term SHALL be absent; behaviour SHALL be REQ-003..REQ-015 only.

Structure
REQ-018 Shared package hazard_pkg SHALL hold:
- T_W=2 (Tnew/Tuse width)
- NREG=32
- MUL_LAT=5, DIV_LAT=10
- MDU_CNT_W=4
REQ-019 The MDU countdown SHALL be a sub-module mdu_busy_tracker, instantiated only under HAZARD_MDU_EN.

Verification
REQ-020 Bench SHALL cover these directed scenarios:
- lw $1 issues (D_Tnew=2, D_wa=1); next D = add rs=1, Tuse=1 -> stall=1 for exactly 1 cycle, then add issues; stall_cycles=1.
- add $2 issues (Tnew=1); next D = beq rs=2, Tuse=0 -> 1-cycle stall; repeat with Tuse_rs=1 -> no stall.
- Producer writes $0 (Tnew=2); next D reads $0 with Tuse=0 -> stall=0.
- lw $3 issues, then reset in the next cycle with dependent D pending -> pend cleared, stall=0 after reset, stall_cycles=0.
- Hold stall asserted continuously for 70000 cycles -> stall_cycles stops at 16'hFFFF.
- HAZARD_MDU_EN: div issues, then mfhi (D_is_md=1) in D -> stall for 10 cycles, md_busy falls, mfhi issues; mult gives 5 cycles.
